// File: rtl/beam_splitter_array.sv
`default_nettype none

`ifndef LONG_DATA_WIDTH
`define LONG_DATA_WIDTH 64
`endif

// ============================================================================
// Module      : beam_splitter_array
// Description : Streams rows of a beam-splitter grid one cell per cycle and
//               keeps one beam count per column. Each committed row moves the
//               column counts through its splitters and adds new beams at its
//               sources. A drain streams the per-column counts out and ends
//               with a one-cycle pulse that carries their saturating sum.
//
// Ports       : clock        rising-edge clock
//               reset        asynchronous active-low reset
//               en           cell_in valid (taken only while ready=1)
//               cell_in      cell code: 00 '.', 01 '^', 10 'S', 11 '.'
//               eol          end of row; commits after any same-cycle cell
//               drain        start a drain (taken only while ready=1)
//               clear        synchronous clear of all state, highest priority
//               ready        block accepts en / eol / drain this cycle
//               count_out    column count while count_valid=1
//               count_valid  one column per cycle during a drain
//               total_out    running, then final, sum of the column counts
//               total_valid  one-cycle pulse carrying the final total
//               split_count  splitters hit by a nonzero beam so far
//               overflow     sticky: some count or sum saturated
//               overrun      sticky: a row had more than LINE_LENGTH cells
//
// Revision    : 1.0 - initial release
// ============================================================================
module beam_splitter_array #(
  parameter int LINE_LENGTH = 141,
  parameter int COUNT_WIDTH = `LONG_DATA_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic [1:0]             cell_in,
  input  logic                   eol,
  input  logic                   drain,
  input  logic                   clear,
  output logic                   ready,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   count_valid,
  output logic [COUNT_WIDTH-1:0] total_out,
  output logic                   total_valid,
  output logic [COUNT_WIDTH-1:0] split_count,
  output logic                   overflow,
  output logic                   overrun
);

  // Column pointer must be able to hold LINE_LENGTH itself ("row full").
  localparam int c_COL_W = $clog2(LINE_LENGTH + 1);
  localparam int c_IDX_W = $clog2(LINE_LENGTH);
  // Split-count adder is wide enough for both operands plus a carry.
  localparam int c_SPL_W = ((COUNT_WIDTH > c_COL_W) ? COUNT_WIDTH : c_COL_W) + 1;

  localparam logic [1:0]         c_SPLIT    = 2'b01;
  localparam logic [1:0]         c_SOURCE   = 2'b10;
  localparam logic [c_COL_W-1:0] c_COL_FULL = c_COL_W'(LINE_LENGTH);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(LINE_LENGTH - 1);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    COMMIT = 2'd1,
    DRAIN  = 2'd2,
    FINAL  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Saturating add; the MSB of the result flags that saturation occurred.
  function automatic logic [COUNT_WIDTH:0] sat_add(
    input logic [COUNT_WIDTH-1:0] a,
    input logic [COUNT_WIDTH-1:0] b
  );
    logic [COUNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[COUNT_WIDTH]) begin
      s = {1'b1, {COUNT_WIDTH{1'b1}}};
    end
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [1:0]             r_mask [LINE_LENGTH];  // current row, '.' when idle
  logic [COUNT_WIDTH-1:0] r_data [LINE_LENGTH];  // per-column beam counts
  logic [c_COL_W-1:0]     r_col;
  logic [c_IDX_W-1:0]     r_idx;
  logic                   r_drain_pend;          // COMMIT continues into DRAIN
  logic [COUNT_WIDTH-1:0] r_total;
  logic [COUNT_WIDTH-1:0] r_split;
  logic                   r_overflow;
  logic                   r_overrun;

  // --------------------------------------------------------------------------
  // Row-commit datapath: every column is recomputed from the old counts only
  // --------------------------------------------------------------------------
  logic [COUNT_WIDTH-1:0] w_new [LINE_LENGTH];
  logic [LINE_LENGTH-1:0] w_is_spl;
  logic [LINE_LENGTH-1:0] w_is_src;
  logic [LINE_LENGTH-1:0] w_hit;
  logic [LINE_LENGTH-1:0] w_col_ovf;

  for (genvar c = 0; c < LINE_LENGTH; c++) begin : g_col
    logic [COUNT_WIDTH-1:0] w_self;
    logic [COUNT_WIDTH-1:0] w_left;
    logic [COUNT_WIDTH-1:0] w_right;
    logic [COUNT_WIDTH-1:0] w_src;
    logic [COUNT_WIDTH:0]   w_s1;
    logic [COUNT_WIDTH:0]   w_s2;
    logic [COUNT_WIDTH:0]   w_s3;

    assign w_is_spl[c] = (r_mask[c] == c_SPLIT);
    assign w_is_src[c] = (r_mask[c] == c_SOURCE);
    assign w_hit[c]    = w_is_spl[c] && (r_data[c] != '0);

    // A splitter blocks the beam in its own column.
    assign w_self = w_is_spl[c] ? '0 : r_data[c];

    // Contributions from beyond the array edges simply do not exist.
    if (c > 0) begin : g_left
      assign w_left = w_is_spl[c-1] ? r_data[c-1] : '0;
    end else begin : g_no_left
      assign w_left = '0;
    end

    if (c < LINE_LENGTH - 1) begin : g_right
      assign w_right = w_is_spl[c+1] ? r_data[c+1] : '0;
    end else begin : g_no_right
      assign w_right = '0;
    end

    assign w_src = w_is_src[c] ? {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : '0;

    assign w_s1 = sat_add(w_self, w_left);
    assign w_s2 = sat_add(w_s1[COUNT_WIDTH-1:0], w_right);
    assign w_s3 = sat_add(w_s2[COUNT_WIDTH-1:0], w_src);

    assign w_new[c]     = w_s3[COUNT_WIDTH-1:0];
    assign w_col_ovf[c] = w_s1[COUNT_WIDTH] | w_s2[COUNT_WIDTH] | w_s3[COUNT_WIDTH];
  end

  // Number of splitters in this row that see a nonzero beam.
  logic [c_COL_W-1:0] w_hits;
  always_comb begin
    w_hits = '0;
    for (int c = 0; c < LINE_LENGTH; c++) begin
      w_hits = w_hits + c_COL_W'(w_hit[c]);
    end
  end

  logic [c_SPL_W-1:0]     w_split_sum;
  logic                   w_split_ovf;
  logic [COUNT_WIDTH-1:0] w_split_next;
  logic                   w_commit_ovf;

  assign w_split_sum  = c_SPL_W'(r_split) + c_SPL_W'(w_hits);
  assign w_split_ovf  = (w_split_sum > c_SPL_W'({COUNT_WIDTH{1'b1}}));
  assign w_split_next = w_split_ovf ? {COUNT_WIDTH{1'b1}} : w_split_sum[COUNT_WIDTH-1:0];
  assign w_commit_ovf = (|w_col_ovf) | w_split_ovf;

  // --------------------------------------------------------------------------
  // Drain datapath
  // --------------------------------------------------------------------------
  logic [COUNT_WIDTH-1:0] w_drain_val;
  logic [COUNT_WIDTH:0]   w_total_sum;

  assign w_drain_val = r_data[r_idx];
  assign w_total_sum = sat_add(r_total, w_drain_val);

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  logic w_take_cell;
  logic w_row_pending;
  logic w_enter_drain;

  assign w_take_cell   = (r_state == ACCEPT) && en && (r_col < c_COL_FULL);
  // A cell or eol arriving together with drain still belongs to the row that
  // must be committed before draining.
  assign w_row_pending = (r_col != '0) || en || eol;
  assign w_enter_drain = (w_next == DRAIN) && (r_state != DRAIN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ACCEPT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ACCEPT: begin
        if (drain) begin
          w_next = w_row_pending ? COMMIT : DRAIN;
        end else if (eol) begin
          w_next = COMMIT;
        end
      end
      COMMIT:  w_next = r_drain_pend ? DRAIN : ACCEPT;
      DRAIN:   if (r_idx == c_IDX_LAST) w_next = FINAL;
      FINAL:   w_next = ACCEPT;
      default: w_next = ACCEPT;
    endcase
    if (clear) begin
      w_next = ACCEPT;
    end
  end

  // Row mask and column counts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < LINE_LENGTH; c++) begin
        r_mask[c] <= 2'b00;
        r_data[c] <= '0;
      end
    end else if (clear) begin
      for (int c = 0; c < LINE_LENGTH; c++) begin
        r_mask[c] <= 2'b00;
        r_data[c] <= '0;
      end
    end else if (r_state == COMMIT) begin
      // Columns never received this row were left at '.' by the previous clear.
      for (int c = 0; c < LINE_LENGTH; c++) begin
        r_mask[c] <= 2'b00;
        r_data[c] <= w_new[c];
      end
    end else if (w_take_cell) begin
      for (int c = 0; c < LINE_LENGTH; c++) begin
        if (r_col == c_COL_W'(c)) begin
          r_mask[c] <= cell_in;
        end
      end
    end
  end

  // Pointers, accumulators and sticky flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_col        <= '0;
      r_idx        <= '0;
      r_drain_pend <= 1'b0;
      r_total      <= '0;
      r_split      <= '0;
      r_overflow   <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (clear) begin
      r_col        <= '0;
      r_idx        <= '0;
      r_drain_pend <= 1'b0;
      r_total      <= '0;
      r_split      <= '0;
      r_overflow   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      case (r_state)
        ACCEPT: begin
          if (en) begin
            // The pointer parks at LINE_LENGTH; extra cells only flag overrun.
            if (r_col < c_COL_FULL) begin
              r_col <= r_col + 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end
          if (drain) begin
            r_drain_pend <= w_row_pending;
          end
        end
        COMMIT: begin
          r_col        <= '0;
          r_drain_pend <= 1'b0;
          r_split      <= w_split_next;
          if (w_commit_ovf) begin
            r_overflow <= 1'b1;
          end
        end
        DRAIN: begin
          r_total <= w_total_sum[COUNT_WIDTH-1:0];
          if (w_total_sum[COUNT_WIDTH]) begin
            r_overflow <= 1'b1;
          end
          r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end
        default: begin
        end
      endcase
      // Each drain starts its sum afresh from column 0.
      if (w_enter_drain) begin
        r_total <= '0;
        r_idx   <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ready       = (r_state == ACCEPT);
  assign count_valid = (r_state == DRAIN);
  assign count_out   = count_valid ? w_drain_val : '0;
  assign total_valid = (r_state == FINAL);
  assign total_out   = r_total;
  assign split_count = r_split;
  assign overflow    = r_overflow;
  assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_beam_splitter_array.sv
`default_nettype none

// ============================================================================
// Module      : tb_beam_splitter_array
// Description : Scoreboard bench for beam_splitter_array. Two instances with
//               LINE_LENGTH=5 share all inputs: one with 64-bit counts and one
//               with 2-bit counts to exercise saturation. A grid-level model
//               predicts every drained value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beam_splitter_array;

  localparam int L = 5;

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic       en      = 1'b0;
  logic [1:0] cell_in = 2'b00;
  logic       eol     = 1'b0;
  logic       drain   = 1'b0;
  logic       clear   = 1'b0;

  logic        ready_a, count_valid_a, total_valid_a, overflow_a, overrun_a;
  logic [63:0] count_out_a, total_out_a, split_a;
  logic        ready_b, count_valid_b, total_valid_b, overflow_b, overrun_b;
  logic [1:0]  count_out_b, total_out_b, split_b;

  beam_splitter_array #(.LINE_LENGTH(L), .COUNT_WIDTH(64)) dut_a (
    .clock(clock), .reset(reset), .en(en), .cell_in(cell_in), .eol(eol),
    .drain(drain), .clear(clear), .ready(ready_a), .count_out(count_out_a),
    .count_valid(count_valid_a), .total_out(total_out_a),
    .total_valid(total_valid_a), .split_count(split_a),
    .overflow(overflow_a), .overrun(overrun_a)
  );

  beam_splitter_array #(.LINE_LENGTH(L), .COUNT_WIDTH(2)) dut_b (
    .clock(clock), .reset(reset), .en(en), .cell_in(cell_in), .eol(eol),
    .drain(drain), .clear(clear), .ready(ready_b), .count_out(count_out_b),
    .count_valid(count_valid_b), .total_out(total_out_b),
    .total_valid(total_valid_b), .split_count(split_b),
    .overflow(overflow_b), .overrun(overrun_b)
  );

  always #5 clock = ~clock;

  // --------------------------------------------------------------------------
  // Check bookkeeping
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Grid model: k=0 is the 64-bit instance, k=1 the 2-bit instance
  // --------------------------------------------------------------------------
  typedef struct {
    longint unsigned total;
    longint unsigned split;
    bit              ovf;
    bit              ovr;
  } fin_t;

  longint unsigned m_data [2][L];
  longint unsigned m_split [2];
  longint unsigned m_max [2];
  bit              m_ovf [2];
  bit              m_ovr;
  int              m_col;
  int              m_row [L];

  longint unsigned q_cnt_a [$];
  longint unsigned q_cnt_b [$];
  fin_t            q_fin_a [$];
  fin_t            q_fin_b [$];

  function automatic longint unsigned clip(input int k, input longint unsigned v);
    if (v > m_max[k]) begin
      m_ovf[k] = 1'b1;
      return m_max[k];
    end
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < L; c++) m_data[k][c] = 0;
      m_split[k] = 0;
      m_ovf[k]   = 1'b0;
    end
    for (int c = 0; c < L; c++) m_row[c] = 0;
    m_ovr = 1'b0;
    m_col = 0;
    q_cnt_a.delete(); q_cnt_b.delete(); q_fin_a.delete(); q_fin_b.delete();
  endfunction

  // One row passes over the grid: '^' (1) splits the beam below it left and
  // right, 'S' (2) adds a new beam, anything else lets beams fall straight.
  function automatic void m_commit();
    for (int k = 0; k < 2; k++) begin
      longint unsigned old [L];
      longint unsigned s;
      int hits;
      hits = 0;
      for (int c = 0; c < L; c++) old[c] = m_data[k][c];
      for (int c = 0; c < L; c++) begin
        s = 0;
        if (m_row[c] != 1) s += old[c];
        if (c > 0) begin
          if (m_row[c-1] == 1) s += old[c-1];
        end
        if (c < L - 1) begin
          if (m_row[c+1] == 1) s += old[c+1];
        end
        if (m_row[c] == 2) s += 1;
        m_data[k][c] = clip(k, s);
        if (m_row[c] == 1 && old[c] != 0) hits++;
      end
      m_split[k] = clip(k, m_split[k] + longint'(hits));
    end
    for (int c = 0; c < L; c++) m_row[c] = 0;
    m_col = 0;
  endfunction

  function automatic void m_drain_expect();
    longint unsigned tot;
    fin_t f;
    if (m_col != 0) m_commit();
    for (int k = 0; k < 2; k++) begin
      tot = 0;
      for (int c = 0; c < L; c++) begin
        if (k == 0) q_cnt_a.push_back(m_data[k][c]);
        else        q_cnt_b.push_back(m_data[k][c]);
        tot += m_data[k][c];
      end
      f.total = clip(k, tot);
      f.split = m_split[k];
      f.ovf   = m_ovf[k];
      f.ovr   = m_ovr;
      if (k == 0) q_fin_a.push_back(f);
      else        q_fin_b.push_back(f);
    end
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: compares whatever the DUTs present against the queues
  // --------------------------------------------------------------------------
  always @(negedge clock) begin
    fin_t f;
    if (count_valid_a) begin
      if (q_cnt_a.size() == 0) chk("count_valid_a_spurious", count_valid_a, 0);
      else                     chk("count_out_a", count_out_a, q_cnt_a.pop_front());
    end
    if (count_valid_b) begin
      if (q_cnt_b.size() == 0) chk("count_valid_b_spurious", count_valid_b, 0);
      else                     chk("count_out_b", 64'(count_out_b), q_cnt_b.pop_front());
    end
    if (total_valid_a) begin
      if (q_fin_a.size() == 0) chk("total_valid_a_spurious", total_valid_a, 0);
      else begin
        f = q_fin_a.pop_front();
        chk("total_out_a", total_out_a, f.total);
        chk("split_count_a", split_a, f.split);
        chk("overflow_a", overflow_a, f.ovf);
        chk("overrun_a", overrun_a, f.ovr);
      end
    end
    if (total_valid_b) begin
      if (q_fin_b.size() == 0) chk("total_valid_b_spurious", total_valid_b, 0);
      else begin
        f = q_fin_b.pop_front();
        chk("total_out_b", 64'(total_out_b), f.total);
        chk("split_count_b", 64'(split_b), f.split);
        chk("overflow_b", overflow_b, f.ovf);
        chk("overrun_b", overrun_b, f.ovr);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(ready_a && ready_b) && n < 40) begin
      tick();
      n++;
    end
    if (!(ready_a && ready_b)) chk("ready_timeout", ready_a & ready_b, 1);
  endtask

  task automatic send_cell(input int code, input bit last);
    wait_ready();
    en      = 1'b1;
    cell_in = 2'(code);
    eol     = last;
    if (m_col < L) begin
      m_row[m_col] = code;
      m_col++;
    end else begin
      m_ovr = 1'b1;
    end
    if (last) m_commit();
    tick();
    en  = 1'b0;
    eol = 1'b0;
  endtask

  task automatic send_eol();
    wait_ready();
    eol = 1'b1;
    m_commit();
    tick();
    eol = 1'b0;
  endtask

  task automatic send_codes(input int codes[$]);
    if (codes.size() == 0) send_eol();
    for (int i = 0; i < codes.size(); i++) begin
      if ($urandom_range(0, 4) == 0) tick();
      send_cell(codes[i], i == codes.size() - 1);
    end
  endtask

  task automatic send_row(input string s);
    int codes[$];
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "^":     codes.push_back(1);
        "S":     codes.push_back(2);
        "#":     codes.push_back(3);
        default: codes.push_back(0);
      endcase
    end
    send_codes(codes);
  endtask

  task automatic do_drain();
    wait_ready();
    drain = 1'b1;
    m_drain_expect();
    tick();
    drain = 1'b0;
  endtask

  task automatic do_clear();
    wait_ready();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready_a"}, ready_a, 1);
    chk({tag, "_count_valid_a"}, count_valid_a, 0);
    chk({tag, "_total_valid_a"}, total_valid_a, 0);
    chk({tag, "_count_out_a"}, count_out_a, 0);
    chk({tag, "_total_out_a"}, total_out_a, 0);
    chk({tag, "_split_a"}, split_a, 0);
    chk({tag, "_overflow_a"}, overflow_a, 0);
    chk({tag, "_overrun_a"}, overrun_a, 0);
    chk({tag, "_count_valid_b"}, count_valid_b, 0);
    chk({tag, "_total_valid_b"}, total_valid_b, 0);
    chk({tag, "_total_out_b"}, 64'(total_out_b), 0);
    chk({tag, "_overflow_b"}, overflow_b, 0);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int codes[$];
    int r;
    m_max[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    m_max[1] = 3;
    model_reset();

    repeat (3) tick();
    chk_zero("in_reset");
    reset = 1'b1;
    tick();
    chk_zero("after_reset");

    // Basic split, then a second row of splitters, then a repeated drain.
    send_row("..S..");
    send_row("..^..");
    do_drain();
    send_row(".^.^.");
    do_drain();
    do_drain();

    // Edge columns: left '^' sees no beam, right contribution is dropped.
    do_clear();
    send_row("^...S");
    send_row("....^");
    do_drain();

    // Overlong row: the two extra cells are ignored and overrun latches.
    do_clear();
    send_row("..S..^#");
    send_row("..^..");
    do_drain();

    // Chained splitters push neighbours past the 2-bit range.
    do_clear();
    send_row("..S..");
    send_row("..S..");
    send_row("..S..");
    send_row(".S^S.");
    do_drain();
    send_row("");
    do_drain();

    // Drain with a partial row pending, then reset in the middle of it.
    do_clear();
    send_row("..S..");
    send_cell(1, 1'b0);
    send_cell(0, 1'b0);
    do_drain();
    repeat (3) tick();
    chk("drain_progress_a", q_cnt_a.size(), 3);
    chk("drain_progress_b", q_cnt_b.size(), 3);
    reset = 1'b0;
    model_reset();
    #1;
    chk_zero("reset_mid_drain");
    repeat (3) tick();
    chk_zero("held_reset");
    reset = 1'b1;
    tick();

    // Randomised rows, drains, clears and empty rows.
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 99);
      if (r < 65) begin
        codes.delete();
        for (int i = 0; i < $urandom_range(0, 7); i++) begin
          case ($urandom_range(0, 9))
            5, 6:    codes.push_back(1);
            7, 8:    codes.push_back(2);
            9:       codes.push_back(3);
            default: codes.push_back(0);
          endcase
        end
        send_codes(codes);
      end else if (r < 88) begin
        do_drain();
      end else if (r < 94) begin
        do_clear();
      end else begin
        send_eol();
      end
    end
    do_drain();
    wait_ready();
    repeat (3) tick();

    chk("queues_empty_a", q_cnt_a.size() + q_fin_a.size(), 0);
    chk("queues_empty_b", q_cnt_b.size() + q_fin_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
